// File: rtl/sequence_detector_param_counter_pkg.sv
// Shared definitions for the parameterised up/down counter: boundary-mode
// encodings and the step-direction type.
package sequence_detector_param_counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/sequence_detector_count_step.sv
// Combinational single-step unit: moves base one count in the requested
// direction and flags when that step crosses a count boundary.
module sequence_detector_count_step
  import sequence_detector_param_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] base,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_value,
  output logic             boundary
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
  localparam bit               SAT   = (SATURATE == MODE_SATURATE);

  always_comb begin
    next_value = base;
    boundary   = 1'b0;
    if (up_down == DIR_UP) begin
      if (base >= MAX_V) begin
        boundary   = 1'b1;
        next_value = SAT ? MAX_V : '0;
      end else begin
        next_value = base + ONE_V;
      end
    end else begin
      if (base == '0) begin
        boundary   = 1'b1;
        next_value = SAT ? '0 : MAX_V;
      end else begin
        next_value = base - ONE_V;
      end
    end
  end

endmodule

// File: rtl/sequence_detector_param_counter.sv
// Bounded up/down counter with clear/load priority mux, wrap or saturate
// boundary behaviour, a one-cycle wrap pulse and a sticky boundary flag.
module sequence_detector_param_counter
  import sequence_detector_param_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             terminal,
  output logic             wrapped,
  output logic             overflow_sticky
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrapped_q, wrapped_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] stepped;
  logic             boundary;
  logic             boundary_event;

  sequence_detector_count_step #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .SATURATE  (SATURATE)
  ) u_step (
    .base       (base),
    .up_down    (up_down),
    .next_value (stepped),
    .boundary   (boundary)
  );

  // Clear and load only choose the starting point; an enabled step still
  // applies on top of it in the same cycle.
  always_comb begin
    base = q_q;
    if (clear) begin
      base = '0;
    end else if (load) begin
      base = (load_value > MAX_V) ? MAX_V : load_value;
    end
  end

  always_comb begin
    boundary_event = enable & boundary;
    q_d            = enable ? stepped : base;
    wrapped_d      = boundary_event && (SATURATE == MODE_WRAP);
    sticky_d       = sticky_q;
    if (boundary_event) begin
      sticky_d = 1'b1;
    end else if (clear) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q       <= '0;
      wrapped_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      q_q       <= q_d;
      wrapped_q <= wrapped_d;
      sticky_q  <= sticky_d;
    end
  end

  assign q               = q_q;
  assign wrapped         = wrapped_q;
  assign overflow_sticky = sticky_q;
  assign terminal        = ((up_down == DIR_UP) && (q_q == MAX_V)) ||
                           ((up_down == DIR_DOWN) && (q_q == '0));

endmodule

// File: tb/tb_sequence_detector_param_counter.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter (WIDTH=4,
// MAX_COUNT=9) driven with directed vectors and hand-computed expectations.
module tb_sequence_detector_param_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_w = 0, en_w = 0, ud_w = 0, clr_w = 0, ld_w = 0;
  logic [3:0] lv_w = '0;
  logic [3:0] q_w;
  logic       term_w, wrap_w, stk_w;

  logic       rst_s = 0, en_s = 0, ud_s = 0, clr_s = 0, ld_s = 0;
  logic [3:0] lv_s = '0;
  logic [3:0] q_s;
  logic       term_s, wrap_s, stk_s;

  sequence_detector_param_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut_w (
    .clock(clk), .reset(rst_w), .enable(en_w), .up_down(ud_w), .clear(clr_w),
    .load(ld_w), .load_value(lv_w), .q(q_w), .terminal(term_w),
    .wrapped(wrap_w), .overflow_sticky(stk_w)
  );

  sequence_detector_param_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) dut_s (
    .clock(clk), .reset(rst_s), .enable(en_s), .up_down(ud_s), .clear(clr_s),
    .load(ld_s), .load_value(lv_s), .q(q_s), .terminal(term_s),
    .wrapped(wrap_s), .overflow_sticky(stk_s)
  );

  typedef struct {
    logic [3:0] q;
    logic       w;
    logic       s;
    string      nm;
  } exp_t;

  exp_t exp_wq[$];
  exp_t exp_sq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: each pushed entry describes the state right after one edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_wq.size() > 0) begin
      e = exp_wq.pop_front();
      cmp({"W ", e.nm, " q"}, q_w, e.q);
      cmp({"W ", e.nm, " wrapped"}, {3'b0, wrap_w}, {3'b0, e.w});
      cmp({"W ", e.nm, " sticky"}, {3'b0, stk_w}, {3'b0, e.s});
    end
    if (exp_sq.size() > 0) begin
      e = exp_sq.pop_front();
      cmp({"S ", e.nm, " q"}, q_s, e.q);
      cmp({"S ", e.nm, " wrapped"}, {3'b0, wrap_s}, {3'b0, e.w});
      cmp({"S ", e.nm, " sticky"}, {3'b0, stk_s}, {3'b0, e.s});
    end
  end

  task automatic step(input bit sel, input logic rst, input logic en, input logic ud,
                      input logic clr, input logic ld, input logic [3:0] lv,
                      input logic [3:0] eq, input logic ew, input logic es,
                      input string nm);
    exp_t e;
    if (!sel) begin
      rst_w = rst; en_w = en; ud_w = ud; clr_w = clr; ld_w = ld; lv_w = lv;
    end else begin
      rst_s = rst; en_s = en; ud_s = ud; clr_s = clr; ld_s = ld; lv_s = lv;
    end
    @(posedge clk);
    #1;
    e.q = eq; e.w = ew; e.s = es; e.nm = nm;
    if (!sel) exp_wq.push_back(e);
    else      exp_sq.push_back(e);
  endtask

  task automatic check_term(input bit sel, input logic ud, input logic req, input string nm);
    if (!sel) begin
      rst_w = 0; en_w = 0; clr_w = 0; ld_w = 0; ud_w = ud; #1;
      cmp({"W term ", nm}, {3'b0, term_w}, {3'b0, req});
    end else begin
      rst_s = 0; en_s = 0; clr_s = 0; ld_s = 0; ud_s = ud; #1;
      cmp({"S term ", nm}, {3'b0, term_s}, {3'b0, req});
    end
  endtask

  localparam bit W = 1'b0;
  localparam bit S = 1'b1;

  initial begin
    // ---------------- wrap instance ----------------
    step(W, 1, 1, 1, 1, 1, 4'd5, 4'd0, 0, 0, "reset");
    for (int i = 1; i <= 9; i++) begin
      step(W, 0, 1, 1, 0, 0, 4'd0, 4'(i), 0, 0, "count up");
    end
    check_term(W, 1, 1, "q9 up");
    check_term(W, 0, 0, "q9 down");
    step(W, 0, 1, 1, 0, 0, 4'd0, 4'd0, 1, 1, "wrap 9->0");
    step(W, 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, "idle after wrap");
    step(W, 0, 0, 1, 0, 1, 4'd7, 4'd7, 0, 1, "load 7");
    step(W, 0, 1, 1, 1, 0, 4'd0, 4'd1, 0, 0, "clear+enable up");
    step(W, 0, 0, 1, 1, 0, 4'd0, 4'd0, 0, 0, "clear alone");
    step(W, 0, 1, 1, 0, 1, 4'd15, 4'd0, 1, 1, "load15 clamp+up");
    step(W, 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, "hold");
    step(W, 0, 0, 1, 0, 1, 4'd15, 4'd9, 0, 1, "load15 clamp");
    step(W, 0, 0, 1, 1, 1, 4'd3, 4'd0, 0, 0, "clear over load");
    check_term(W, 0, 1, "q0 down");
    check_term(W, 1, 0, "q0 up");
    step(W, 0, 1, 0, 0, 0, 4'd0, 4'd9, 1, 1, "wrap 0->9");
    step(W, 0, 1, 0, 0, 0, 4'd0, 4'd8, 0, 1, "down 9->8");
    step(W, 0, 0, 0, 0, 1, 4'd4, 4'd4, 0, 1, "load 4");
    step(W, 0, 1, 1, 0, 0, 4'd0, 4'd5, 0, 1, "up to 5");
    step(W, 1, 1, 1, 0, 1, 4'd3, 4'd0, 0, 0, "reset mid-count");
    step(W, 0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0, "resume after reset");
    step(W, 0, 0, 1, 0, 0, 4'd0, 4'd1, 0, 0, "idle");

    // ---------------- saturate instance ----------------
    step(S, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "reset");
    step(S, 0, 0, 0, 0, 1, 4'd2, 4'd2, 0, 0, "load 2");
    step(S, 0, 1, 0, 0, 0, 4'd0, 4'd1, 0, 0, "down 2->1");
    step(S, 0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0, "down 1->0");
    step(S, 0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 1, "sat hold 0 a");
    step(S, 0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 1, "sat hold 0 b");
    step(S, 0, 1, 1, 0, 1, 4'd8, 4'd9, 0, 1, "load8+up");
    step(S, 0, 1, 1, 0, 0, 4'd0, 4'd9, 0, 1, "sat hold 9");
    check_term(S, 1, 1, "q9 up");
    check_term(S, 0, 0, "q9 down");
    step(S, 0, 1, 0, 1, 0, 4'd0, 4'd0, 0, 1, "clear+boundary");
    step(S, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, "clear alone");
    step(S, 0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0, "up 0->1");
    step(S, 0, 1, 1, 0, 1, 4'd15, 4'd9, 0, 1, "load15 clamp+up");
    step(S, 0, 0, 1, 0, 0, 4'd0, 4'd9, 0, 1, "hold");

    for (int i = 0; i < 10 && (exp_wq.size() > 0 || exp_sq.size() > 0); i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_wq.size() > 0 || exp_sq.size() > 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_wq.size() + exp_sq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
